// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, the imem request/ready handshake
// and the IF/ID register, with hazard stalls and branch flush/redirect.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_inc;
    logic [31:0] br_target;

    // Hold buffer: a word that returned while ID was stalled.
    logic [31:0] hold_instr_p0;
    logic [31:0] hold_pc_p0;
    logic        vld_p0;

    logic ld_mem;
    logic ld_hold;
    logic cap_hold;
    logic flush;
    logic bubble;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    assign pc_inc    = pc + STEP;
    assign br_target = align_word(branch_address);

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign pc_out    = pc;

    // A taken branch outranks every other condition, in every state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ld_mem    = 1'b0;
        ld_hold   = 1'b0;
        cap_hold  = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        if (branch_taken) begin
            pc_nxt    = br_target;
            flush     = 1'b1;
            state_nxt = ST_REDIRECT;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_nxt = pc_inc;
                        if (hazard_stall) begin
                            cap_hold  = 1'b1;
                            state_nxt = ST_HOLD;
                        end else begin
                            ld_mem = 1'b1;
                        end
                    end else if (!hazard_stall) begin
                        bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!hazard_stall) begin
                        ld_hold   = vld_p0;
                        state_nxt = ST_FETCH;
                    end
                end
                ST_REDIRECT: begin
                    state_nxt = ST_FETCH;
                end
                default: begin
                    state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_instr_p0 <= 32'h0;
            hold_pc_p0    <= 32'h0;
            vld_p0        <= 1'b0;
        end else begin
            if (cap_hold) begin
                hold_instr_p0 <= imem_rdata;
                hold_pc_p0    <= pc_inc;
            end
            if (flush || ld_hold) begin
                vld_p0 <= 1'b0;
            end else if (cap_hold) begin
                vld_p0 <= 1'b1;
            end
        end
    end

    // IF/ID stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr <= 32'h0;
            if_id_pc    <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            if (ld_mem) begin
                if_id_instr <= imem_rdata;
                if_id_pc    <= pc_inc;
            end else if (ld_hold) begin
                if_id_instr <= hold_instr_p0;
                if_id_pc    <= hold_pc_p0;
            end
            if (flush || bubble) begin
                if_id_valid <= 1'b0;
            end else if (ld_mem || ld_hold) begin
                if_id_valid <= 1'b1;
            end
            if (ld_mem || ld_hold) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage. It owns the program counter and drives the instruction-memory request/ready handshake. It also owns the IF/ID pipeline register, applying stalls from the hazard unit and flushes and redirects on taken branches. It sits between instruction memory and the ID stage, replacing free-running PC+4 fetch with a handshaked, stallable and flushable fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  in  1  clock; all state on posedge.
rst  in  1  asynchronous, active-high reset.
hazard_stall  in  1  ID stage cannot accept; hold IF/ID contents.
branch_taken  in  1  redirect request, 1-cycle pulse.
branch_address  in  32  redirect target; bits [1:0] ignored (forced 0).
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; equals pc while imem_req=1.
imem_ready  in  1  memory returns imem_rdata this cycle; only sampled while imem_req=1.
imem_rdata  in  32  instruction word.
pc_out  out  32  current fetch PC.
if_id_instr  out  32  instruction to ID.
if_id_pc  out  32  PC+PC_STEP of that instruction.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_count  out  32  number of instructions delivered to IF/ID (valid loads).

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=BOOT, imem_req=0, if_id_instr=0, if_id_pc=0, if_id_valid=0, fetch_count=0, hold buffer empty. Asserting reset mid-transaction aborts it; the memory must tolerate imem_req dropping.
- States: BOOT, FETCH, HOLD, REDIRECT. imem_req=1 only in FETCH.
- BOOT: one cycle, imem_req=0, then FETCH.
- FETCH, imem_ready=1, hazard_stall=0:
  - if_id_instr<=imem_rdata, if_id_pc<=pc+PC_STEP, if_id_valid<=1, fetch_count++, pc<=pc+PC_STEP.
  - Stay in FETCH; next request issues the following cycle, giving 1 instruction/cycle with a zero-wait memory.
- FETCH, imem_ready=1, hazard_stall=1:
  - IF/ID unchanged.
  - imem_rdata and pc+PC_STEP captured into the hold buffer; pc<=pc+PC_STEP; go HOLD.
- FETCH, imem_ready=0: if hazard_stall=0, if_id_valid<=0 (bubble); if stall=1, IF/ID unchanged. imem_addr held stable.
- HOLD: imem_req=0. When hazard_stall=0, load IF/ID from the hold buffer (valid<=1, fetch_count++), then go FETCH. If stall remains, stay.
- branch_taken=1 in any non-reset state has highest priority, above stall and ready:
  - pc<={branch_address[31:2],2'b00}, if_id_valid<=0, hold buffer discarded.
  - Any imem_rdata returned that cycle is discarded; fetch_count is not incremented.
  - Go REDIRECT.
- REDIRECT: imem_req=0 for exactly one cycle (memory abort), then FETCH at the new pc. A branch_taken arriving in REDIRECT re-targets pc and stays in REDIRECT one more cycle.
- Flush overrides stall: a flushed IF/ID is invalid even while hazard_stall=1.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 = 0. fetch_count wraps at 2^32.
- pc_out always equals the internal pc register.
- Outputs are registered except imem_req and imem_addr (decoded from state and pc).
- Delivery latency from imem_ready to if_id_valid=1 is 1 clock.

Test Plan:
1. Reset, then imem_ready tied 1, no stall. Required: BOOT 1 cycle; imem_addr sequence 0,4,8,12; if_id_pc 4,8,12; fetch_count=3 after 3 deliveries.
2. Stall at ready: stall asserted on the cycle word at addr 8 returns, held 3 cycles. Required: IF/ID keeps the addr-4 instruction; state HOLD with imem_req=0; on release, IF/ID gets the addr-8 word with if_id_pc=12; next fetch is at 12; no word lost or duplicated.
3. Branch while memory busy (imem_ready=0, addr 16), branch_taken with target 0x103. Required: if_id_valid=0 next cycle; imem_req=0 for 1 cycle; next fetch imem_addr=0x100; late ready data discarded.
4. Branch and stall in the same cycle, in HOLD. Required: hold buffer dropped, if_id_valid=0, pc=target, fetch_count unchanged.
5. Wrap: RESET_PC=32'hFFFF_FFFC, ready=1. Required: fetch addresses FFFF_FFFC then 0000_0000; if_id_pc=0.
6. Async reset pulse mid-FETCH between clock edges. Required: imem_req=0 and if_id_valid=0 immediately; pc=RESET_PC; restart via BOOT.
